// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq: registered ALU with an iterative shift-add multiplier.
//
// Ports:
//   clk, rst_           clock, asynchronous active-low reset
//   accum, data         operands (accumulator, bus), sampled with start
//   op                  operation code, sampled with start
//   start               operation request
//   out                 registered result
//   carry               registered carry / borrow / overflow flag
//   res_zero            registered, 1 when out is all zeros
//   err                 one-cycle pulse with done for an illegal op
//   zero                combinational ~|accum, for the controller's skip test
//   busy                high while a multiply iterates
//   done                one-cycle pulse after out/flags were written
//   dbg_state_o         current FSM state (0 = IDLE, 1 = MUL)
//
// Handshake: a request is taken on any rising edge where start=1 and
// busy=0; start while busy=1 is dropped, never queued. Each accepted request
// produces exactly one done pulse: in the cycle right after the accepting
// edge for single-cycle ops, and WIDTH edges after it for MUL. busy is
// already 0 while done is high, so a start in the done cycle is accepted.
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [WIDTH-1:0] accum,
    input  logic [WIDTH-1:0] data,
    input  logic [3:0]       op,
    input  logic             start,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             res_zero,
    output logic             err,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             dbg_state_o
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       out_q, out_d;
    logic                   carry_q, carry_d;
    logic                   rz_q, rz_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;
    logic [2*WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [2*WIDTH-1:0]     prod_q, prod_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [WIDTH:0]         sum_w;
    logic [WIDTH:0]         diff_w;
    logic [2*WIDTH-1:0]     prod_nxt;
    logic [WIDTH-1:0]       op_res;
    logic                   op_carry;
    logic                   op_legal;
    logic                   op_is_mul;

    // The extra top bit is the carry-out for ADD and, for SUB, it is set
    // exactly when accum < data (borrow).
    assign sum_w  = {1'b0, accum} + {1'b0, data};
    assign diff_w = {1'b0, accum} - {1'b0, data};

    // Single-cycle result; illegal ops reproduce the held out value.
    always_comb begin
        op_res    = accum;
        op_carry  = 1'b0;
        op_legal  = 1'b1;
        op_is_mul = 1'b0;
        case (op)
            4'd0: op_res = accum;
            4'd1: begin
                op_res   = sum_w[WIDTH-1:0];
                op_carry = sum_w[WIDTH];
            end
            4'd2: begin
                op_res   = diff_w[WIDTH-1:0];
                op_carry = diff_w[WIDTH];
            end
            4'd3: op_res = accum & data;
            4'd4: op_res = accum | data;
            4'd5: op_res = accum ^ data;
            4'd6: op_res = data;
            4'd7: begin
                op_res   = {accum[WIDTH-2:0], 1'b0};
                op_carry = accum[WIDTH-1];
            end
            4'd8: begin
                op_res   = {1'b0, accum[WIDTH-1:1]};
                op_carry = accum[0];
            end
            4'd9: begin
                op_is_mul = MUL_EN;
                op_legal  = MUL_EN;
                op_res    = out_q;
            end
            default: begin
                op_legal = 1'b0;
                op_res   = out_q;
            end
        endcase
    end

    // Partial product including the current multiplier bit; on the last
    // iteration this is the complete product.
    assign prod_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        carry_d  = carry_q;
        rz_d     = rz_q;
        err_d    = 1'b0;
        done_d   = 1'b0;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op_is_mul) begin
                        mcand_d  = {{WIDTH{1'b0}}, accum};
                        mplier_d = data;
                        prod_d   = '0;
                        cnt_d    = '0;
                        state_d  = S_MUL;
                    end else begin
                        out_d   = op_res;
                        carry_d = op_carry;
                        rz_d    = ~|op_res;
                        err_d   = ~op_legal;
                        done_d  = 1'b1;
                    end
                end
            end
            S_MUL: begin
                prod_d   = prod_nxt;
                mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    out_d   = prod_nxt[WIDTH-1:0];
                    carry_d = |prod_nxt[2*WIDTH-1:WIDTH];
                    rz_d    = ~|prod_nxt[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= S_IDLE;
            out_q    <= '0;
            carry_q  <= 1'b0;
            rz_q     <= 1'b1;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            carry_q  <= carry_d;
            rz_q     <= rz_d;
            err_q    <= err_d;
            done_q   <= done_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out         = out_q;
    assign carry       = carry_q;
    assign res_zero    = rz_q;
    assign err         = err_q;
    assign done        = done_q;
    assign busy        = (state_q == S_MUL);
    assign zero        = ~|accum;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq: directed bench for alu_seq. Three instances share one clock
// and reset: s=0 WIDTH=8 MUL_EN=1, s=1 WIDTH=8 MUL_EN=0, s=2 WIDTH=16.
// Expected {err, carry, out} words come from an arithmetic reference model
// and are queued at issue time, then popped when done pulses.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    logic clk = 1'b0;
    logic rst_;
    always #5 clk = ~clk;

    logic [15:0] a_s [3];
    logic [15:0] b_s [3];
    logic [3:0]  op_s [3];
    logic        st_s [3];
    logic [15:0] mprev [3];

    logic [7:0]  out0, out1;
    logic [15:0] out2;
    logic c0, c1, c2, rz0, rz1, rz2, er0, er1, er2, z0, z1, z2;
    logic bz0, bz1, bz2, dn0, dn1, dn2, dbg0, dbg1, dbg2;

    int n_assert = 0;
    int n_fail   = 0;
    logic [17:0] exp_q [$];

    alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) u_d0 (
        .clk(clk), .rst_(rst_), .accum(a_s[0][7:0]), .data(b_s[0][7:0]),
        .op(op_s[0]), .start(st_s[0]), .out(out0), .carry(c0), .res_zero(rz0),
        .err(er0), .zero(z0), .busy(bz0), .done(dn0), .dbg_state_o(dbg0)
    );
    alu_seq #(.WIDTH(8), .MUL_EN(1'b0)) u_d1 (
        .clk(clk), .rst_(rst_), .accum(a_s[1][7:0]), .data(b_s[1][7:0]),
        .op(op_s[1]), .start(st_s[1]), .out(out1), .carry(c1), .res_zero(rz1),
        .err(er1), .zero(z1), .busy(bz1), .done(dn1), .dbg_state_o(dbg1)
    );
    alu_seq #(.WIDTH(16), .MUL_EN(1'b1)) u_d2 (
        .clk(clk), .rst_(rst_), .accum(a_s[2]), .data(b_s[2]),
        .op(op_s[2]), .start(st_s[2]), .out(out2), .carry(c2), .res_zero(rz2),
        .err(er2), .zero(z2), .busy(bz2), .done(dn2), .dbg_state_o(dbg2)
    );

    function automatic int w_of(input int s);
        return (s == 2) ? 16 : 8;
    endfunction

    function automatic bit men(input int s);
        return (s != 1);
    endfunction

    function automatic logic [15:0] get_out(input int s);
        case (s)
            0: return {8'h00, out0};
            1: return {8'h00, out1};
            default: return out2;
        endcase
    endfunction

    // Packs {busy, done, err, res_zero, carry} for one instance.
    function automatic logic [4:0] get_fl(input int s);
        case (s)
            0: return {bz0, dn0, er0, rz0, c0};
            1: return {bz1, dn1, er1, rz1, c1};
            default: return {bz2, dn2, er2, rz2, c2};
        endcase
    endfunction

    // Reference model: returns {err, carry, out[15:0]}.
    function automatic logic [17:0] model(input int w, input bit mul_en,
                                          input logic [3:0] op,
                                          input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] prev);
        logic [31:0] aa, bb, r, mask;
        logic c, e;
        aa = {16'h0, a};
        bb = {16'h0, b};
        mask = (32'd1 << w) - 32'd1;
        c = 1'b0;
        e = 1'b0;
        r = 32'd0;
        case (op)
            4'd0: r = aa;
            4'd1: begin r = aa + bb; c = r[w]; end
            4'd2: begin r = aa - bb; c = (aa < bb); end
            4'd3: r = aa & bb;
            4'd4: r = aa | bb;
            4'd5: r = aa ^ bb;
            4'd6: r = bb;
            4'd7: begin r = aa << 1; c = aa[w-1]; end
            4'd8: begin r = aa >> 1; c = aa[0]; end
            4'd9: begin
                if (mul_en) begin
                    r = aa * bb;
                    c = ((r >> w) != 32'd0);
                end else begin
                    r = {16'h0, prev};
                    e = 1'b1;
                end
            end
            default: begin r = {16'h0, prev}; e = 1'b1; end
        endcase
        r = r & mask;
        return {e, c, r[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one request and returns 1 ns after the accepting edge.
    task automatic issue(input int s, input logic [3:0] op,
                         input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        a_s[s]  = a;
        b_s[s]  = b;
        op_s[s] = op;
        st_s[s] = 1'b1;
        @(posedge clk);
        #1;
        st_s[s] = 1'b0;
    endtask

    task automatic push_exp(input int s, input logic [3:0] op,
                            input logic [15:0] a, input logic [15:0] b);
        logic [17:0] e;
        e = model(w_of(s), men(s), op, a, b, mprev[s]);
        exp_q.push_back(e);
        mprev[s] = e[15:0];
    endtask

    // Waits (bounded) for done, checks latency and the scoreboard entry.
    task automatic wait_result(input int s, input int lat, input string tag);
        int n;
        logic [17:0] e;
        n = 0;
        while (get_fl(s)[3] !== 1'b1 && n < lat + 4) begin
            chk({tag, "_busy"}, {15'h0, get_fl(s)[4]}, 16'h1);
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, n[15:0], lat[15:0]);
        chk({tag, "_done"}, {15'h0, get_fl(s)[3]}, 16'h1);
        chk({tag, "_busy_at_done"}, {15'h0, get_fl(s)[4]}, 16'h0);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '1;
        chk({tag, "_out"}, get_out(s), e[15:0]);
        chk({tag, "_carry"}, {15'h0, get_fl(s)[0]}, {15'h0, e[16]});
        chk({tag, "_err"}, {15'h0, get_fl(s)[2]}, {15'h0, e[17]});
        chk({tag, "_res_zero"}, {15'h0, get_fl(s)[1]}, {15'h0, (e[15:0] == 16'h0)});
    endtask

    task automatic run_op(input int s, input logic [3:0] op,
                          input logic [15:0] a, input logic [15:0] b, input string tag);
        int lat;
        lat = (op == 4'd9 && men(s)) ? w_of(s) : 0;
        push_exp(s, op, a, b);
        issue(s, op, a, b);
        wait_result(s, lat, tag);
    endtask

    // One idle cycle: pulses must have ended and out must hold.
    task automatic quiet(input int s, input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_q_done"}, {15'h0, get_fl(s)[3]}, 16'h0);
        chk({tag, "_q_err"}, {15'h0, get_fl(s)[2]}, 16'h0);
        chk({tag, "_q_busy"}, {15'h0, get_fl(s)[4]}, 16'h0);
        chk({tag, "_q_out"}, get_out(s), mprev[s]);
    endtask

    initial begin
        int ndone;
        logic [3:0]  rop;
        logic [15:0] ra, rb;

        rst_ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_s[i] = '0; b_s[i] = '0; op_s[i] = '0; st_s[i] = 1'b0; mprev[i] = '0;
        end

        // Reset values, and zero tracking accum even while in reset.
        #12;
        chk("rst_out", get_out(0), 16'h0);
        chk("rst_flags", {11'h0, get_fl(0)}, 16'h0002);
        chk("rst_out16", get_out(2), 16'h0);
        chk("rst_flags16", {11'h0, get_fl(2)}, 16'h0002);
        chk("rst_state", {15'h0, dbg0}, 16'h0);
        #1;
        chk("zero_on_0", {15'h0, z0}, 16'h1);
        a_s[0] = 16'h0005;
        #1;
        chk("zero_on_5", {15'h0, z0}, 16'h0);
        a_s[0] = 16'h0000;
        @(negedge clk);
        rst_ = 1'b1;

        // Directed single-cycle ops.
        run_op(0, 4'd1, 16'hFF, 16'h01, "add_ff_01");
        quiet(0, "add_ff_01");
        run_op(0, 4'd2, 16'h10, 16'h20, "sub_borrow");
        run_op(0, 4'd7, 16'h81, 16'h00, "shl_81");
        run_op(0, 4'd8, 16'h01, 16'h00, "shr_01");
        run_op(0, 4'd3, 16'hF0, 16'h3C, "and");
        run_op(0, 4'd4, 16'hF0, 16'h0C, "or");
        run_op(0, 4'd5, 16'hFF, 16'h0F, "xor");
        run_op(0, 4'd6, 16'h11, 16'hA5, "lda");
        run_op(0, 4'd0, 16'h5A, 16'hA5, "pass");
        run_op(0, 4'd2, 16'h20, 16'h20, "sub_equal");

        // MUL, then MUL issued in the done cycle of the first one.
        run_op(0, 4'd9, 16'h0F, 16'h11, "mul_0f_11");
        run_op(0, 4'd9, 16'h10, 16'h10, "mul_10_10");
        run_op(0, 4'd1, 16'h01, 16'h02, "add_after_mul");
        quiet(0, "add_after_mul");

        // Operand changes and a start during MUL are ignored.
        push_exp(0, 4'd9, 16'h07, 16'h09);
        issue(0, 4'd9, 16'h07, 16'h09);
        @(negedge clk);
        a_s[0] = 16'hAA; b_s[0] = 16'h55; op_s[0] = 4'd1; st_s[0] = 1'b1;
        @(posedge clk);
        #1;
        st_s[0] = 1'b0;
        wait_result(0, 7, "mul_disturbed");
        quiet(0, "mul_disturbed");
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (dn0 === 1'b1) ndone++;
        end
        chk("mul_disturbed_extra_done", ndone[15:0], 16'h0);

        // Reset in the middle of a MUL aborts it with no done.
        issue(0, 4'd9, 16'h0F, 16'h11);
        repeat (3) @(posedge clk);
        #3;
        rst_ = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) mprev[i] = '0;
        chk("abort_out", get_out(0), 16'h0);
        chk("abort_flags", {11'h0, get_fl(0)}, 16'h0002);
        chk("abort_state", {15'h0, dbg0}, 16'h0);
        @(negedge clk);
        rst_ = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (dn0 === 1'b1) ndone++;
        end
        chk("abort_no_done", ndone[15:0], 16'h0);
        run_op(0, 4'd1, 16'h12, 16'h34, "add_after_abort");

        // Illegal ops: out held, carry forced low, err with done.
        run_op(0, 4'd1, 16'hFF, 16'h02, "add_carry_set");
        run_op(0, 4'hF, 16'h33, 16'h44, "illegal_f");
        quiet(0, "illegal_f");
        run_op(0, 4'hA, 16'h00, 16'h00, "illegal_a");
        run_op(1, 4'd1, 16'h80, 16'h80, "nomul_add");
        run_op(1, 4'd9, 16'h03, 16'h04, "nomul_op9");
        quiet(1, "nomul_op9");
        run_op(1, 4'd2, 16'h05, 16'h03, "nomul_sub");

        // WIDTH=16 instance.
        run_op(2, 4'd1, 16'hFFFF, 16'h0001, "w16_add");
        run_op(2, 4'd9, 16'hFFFF, 16'h0002, "w16_mul_ffff_2");
        run_op(2, 4'd9, 16'h0100, 16'h0100, "w16_mul_ovf");
        run_op(2, 4'd9, 16'h00FF, 16'h0101, "w16_mul_ffff");
        quiet(2, "w16_mul");

        // Random mix on the 8-bit instance, including illegal codes.
        for (int i = 0; i < 8; i++) begin
            rop = 4'($urandom_range(0, 11));
            ra  = 16'($urandom_range(0, 255));
            rb  = 16'($urandom_range(0, 255));
            run_op(0, rop, ra, rb, "rand");
        end
        quiet(0, "rand");

        chk("queue_empty", 16'(exp_q.size()), 16'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
